// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one character per valid/ready handshake,
// configurable data width, parity, stop bits and baud divider. All outputs registered.
module uart_tx_param #(
  parameter int unsigned CLK_FREQ  = 16000000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 idle,
  output logic                 tx_done
);

  localparam int unsigned Div  = CLK_FREQ / BAUD;
  // Guarded so an illegal Div still reaches the elaboration error below.
  localparam int unsigned CntW = (Div >= 2) ? $clog2(Div) : 1;
  localparam int unsigned IdxW = $clog2(DATA_BITS + 1);

  if (Div < 2) begin : g_bad_div
    $error("uart_tx_param: CLK_FREQ / BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {StIdle, StStart, StData, StPar, StStop} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   stop_q, stop_d;
  logic                   tx_q, tx_d;
  logic                   idle_q, idle_d;
  logic                   done_q, done_d;
  logic                   bit_end;

  assign bit_end = (cnt_q == CntW'(Div - 1));

  // Next-state logic; tx_d is the line value for the bit that starts at the next edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    stop_d  = stop_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
          // Odd parity inverts the data XOR so data+parity has an odd count of ones.
          par_d   = (PARITY == 1) ? ~(^tx_data) : (^tx_data);
          cnt_d   = '0;
          idx_d   = '0;
          stop_d  = 1'b0;
          tx_d    = 1'b0;
          state_d = StStart;
        end
      end
      StStart: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = StPar;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            idx_d   = idx_q + IdxW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end
      end
      StPar: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          tx_d    = 1'b1;
          state_d = StStop;
        end
      end
      StStop: begin
        cnt_d = bit_end ? '0 : cnt_q + CntW'(1);
        if (bit_end) begin
          if (stop_q == 1'(STOP_BITS - 1)) begin
            tx_d    = 1'b1;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = StIdle;
      end
    endcase

    idle_d = (state_d == StIdle);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      stop_q  <= 1'b0;
      tx_q    <= 1'b1;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      stop_q  <= stop_d;
      tx_q    <= tx_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
    end
  end

  assign tx       = tx_q;
  assign idle     = idle_q;
  assign tx_ready = idle_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances (8N1, 8E1, 8O1, 7O2) at DIV=16, a line
// receiver per instance checked against a scoreboard, plus timing/corner sequences.
module tb_uart_tx_param;

  localparam int Div = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] din [4];
  logic       vld [4];
  logic       rdy [4];
  logic       txl [4];
  logic       idl [4];
  logic       dn  [4];
  logic       rx_par [4];

  typedef struct {
    int         inst;
    logic [8:0] data;
  } sb_t;
  sb_t sb_q[$];

  typedef struct {
    int         inst;
    logic [8:0] data;
    logic       exp_par;
    int         exp_done;
  } vec_t;
  vec_t vecs [8];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic model_par(input logic [8:0] d, input int db, input int pm);
    logic x;
    x = 1'b0;
    for (int i = 0; i < db; i++) x = x ^ d[i];
    return (pm == 1) ? ~x : x;
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int Db = (g == 3) ? 7 : 8;
    localparam int Pm = (g == 1) ? 2 : ((g == 0) ? 0 : 1);
    localparam int Sb = (g == 3) ? 2 : 1;
    localparam int Nb = 1 + Db + ((Pm != 0) ? 1 : 0) + Sb;

    uart_tx_param #(
      .CLK_FREQ (16000000),
      .BAUD     (1000000),
      .DATA_BITS(Db),
      .PARITY   (Pm),
      .STOP_BITS(Sb)
    ) u_dut (
      .clk     (clk),
      .rst     (rst),
      .tx_data (din[g][Db-1:0]),
      .tx_valid(vld[g]),
      .tx_ready(rdy[g]),
      .tx      (txl[g]),
      .idle    (idl[g]),
      .tx_done (dn[g])
    );

    // Line receiver: samples mid-bit, aborts on reset, pops the scoreboard per frame.
    initial begin : rx_mon
      logic [15:0] bits;
      logic [15:0] ef;
      logic [8:0]  got;
      sb_t         item;
      bit          ab;
      int          w;
      int          p;
      forever begin
        @(negedge clk);
        if (!rst && txl[g] === 1'b0) begin
          ab   = 1'b0;
          bits = '0;
          for (int b = 0; b < Nb; b++) begin
            if (!ab) begin
              w = (b == 0) ? (Div / 2 - 1) : Div;
              for (int i = 0; i < w; i++) begin
                @(negedge clk);
                if (rst) ab = 1'b1;
              end
              bits[b] = txl[g];
            end
          end
          if (!ab) begin
            if (sb_q.size() == 0) begin
              check($sformatf("rx%0d_unexpected_frame", g), {16'h0, bits}, 32'h0);
            end else begin
              item = sb_q.pop_front();
              check($sformatf("rx%0d_inst", g), item.inst, g);
              got = '0;
              for (int i = 0; i < Db; i++) got[i] = bits[i+1];
              check($sformatf("rx%0d_char", g), got, item.data & ((9'h1 << Db) - 9'h1));
              ef = '0;
              p  = 1;
              for (int i = 0; i < Db; i++) begin
                ef[p] = item.data[i];
                p++;
              end
              if (Pm != 0) begin
                ef[p] = model_par(item.data, Db, Pm);
                p++;
              end
              for (int i = 0; i < Sb; i++) begin
                ef[p] = 1'b1;
                p++;
              end
              check($sformatf("rx%0d_frame_bits", g), bits, ef);
              rx_par[g] = (Pm != 0) ? bits[Db+1] : 1'b0;
            end
          end
        end
      end
    end
  end

  // Sends one character on instance g and checks busy/ready/done timing.
  task automatic send(input int g, input logic [8:0] d, input int exp_done);
    int first;
    int cnt;
    sb_t it;
    @(posedge clk);
    #1;
    it.inst = g;
    it.data = d;
    sb_q.push_back(it);
    din[g] = d;
    vld[g] = 1'b1;
    @(posedge clk);
    #1;
    vld[g] = 1'b0;
    din[g] = 9'($urandom);
    first  = -1;
    cnt    = 0;
    for (int i = 1; i <= exp_done + 4; i++) begin
      @(negedge clk);
      if (i == 1) check("busy_after_accept", {txl[g], rdy[g], idl[g]}, 3'b000);
      if (dn[g]) begin
        cnt++;
        if (first < 0) first = i;
      end
      if (i == exp_done) check("ready_low_last_cycle", {rdy[g], idl[g]}, 2'b00);
      if (i == exp_done + 1) check("ready_at_done", {rdy[g], idl[g], txl[g]}, 3'b111);
    end
    check("done_cycle", first, exp_done + 1);
    check("done_count", cnt, 1);
  endtask

  initial begin : main
    int first;
    int cnt;
    bit seen;
    sb_t it;

    vecs[0] = '{0, 9'h055, 1'b0, 160};
    vecs[1] = '{1, 9'h003, 1'b0, 176};
    vecs[2] = '{2, 9'h003, 1'b1, 176};
    vecs[3] = '{1, 9'h007, 1'b1, 176};
    vecs[4] = '{3, 9'h07F, 1'b0, 176};
    vecs[5] = '{2, 9'h0FF, 1'b1, 176};
    vecs[6] = '{1, 9'h0A5, 1'b0, 176};
    vecs[7] = '{3, 9'h001, 1'b0, 176};

    // Reset with tx_valid asserted: must be ignored.
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      vld[g]    = 1'b1;
      din[g]    = 9'($urandom);
      rx_par[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 4; g++) check("reset_state", {txl[g], rdy[g], idl[g], dn[g]}, 4'b1110);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int g = 0; g < 4; g++) vld[g] = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 4; g++) check("post_reset", {txl[g], rdy[g], idl[g], dn[g]}, 4'b1110);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].inst, vecs[v].data, vecs[v].exp_done);
      if (vecs[v].inst != 0) check($sformatf("parity_v%0d", v), rx_par[vecs[v].inst],
                                   vecs[v].exp_par);
    end

    // Back-to-back 0xA5, 0x3C with tx_valid held on the 8N1 instance.
    @(posedge clk);
    #1;
    it.inst = 0;
    it.data = 9'h0A5;
    sb_q.push_back(it);
    it.data = 9'h03C;
    sb_q.push_back(it);
    din[0] = 9'h0A5;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    din[0] = 9'h03C;
    first  = -1;
    for (int i = 1; i <= 400 && first < 0; i++) begin
      @(negedge clk);
      if (rdy[0]) begin
        first = i;
        check("b2b_gap_line", {txl[0], dn[0]}, 2'b11);
      end
    end
    check("b2b_ready_cycle", first, 161);
    @(negedge clk);
    check("b2b_second_start", {rdy[0], txl[0]}, 2'b00);
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    seen   = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dn[0]) seen = 1'b1;
    end
    check("b2b_second_done", seen, 1'b1);

    // Input churn while busy on the 8E1 instance: captured value wins, no second frame.
    @(posedge clk);
    #1;
    it.inst = 1;
    it.data = 9'h05A;
    sb_q.push_back(it);
    din[1] = 9'h05A;
    vld[1] = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 150; i++) begin
      #1;
      din[1] = 9'($urandom);
      vld[1] = i[0];
      @(posedge clk);
    end
    #1;
    vld[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (dn[1]) seen = 1'b1;
    end
    check("churn_done", seen, 1'b1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!idl[1]) cnt++;
    end
    check("churn_no_second_frame", cnt, 0);

    // Reset for one cycle mid-DATA of 0xFF, then a clean 0x00.
    @(posedge clk);
    #1;
    din[0] = 9'h0FF;
    vld[0] = 1'b1;
    @(posedge clk);
    #1;
    vld[0] = 1'b0;
    repeat (Div * 3 + 5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_state", {txl[0], idl[0], rdy[0], dn[0]}, 4'b1110);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dn[0]) cnt++;
      if (!idl[0]) cnt++;
    end
    check("abort_quiet", cnt, 0);
    send(0, 9'h000, 160);

    repeat (20) @(posedge clk);
    check("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
